multicycle_ctrl: RTL and testbench
==================================

# multicycle_ctrl

Main control FSM for the multi-cycle MIPS CPU. It sequences the shared datapath (PC, unified memory port, IR, register file, single ALU) through fetch, decode, execute, memory and write-back, one instruction at a time. It drives the 4-bit ALUOp consumed by the ALU control decoder, stalls on a memory ready handshake, counts retired instructions and traps on illegal opcodes.

## Interface
- No parameters.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- opcode  in  6  IR[31:26].
- funct  in  6  IR[5:0].
- zero  in  1  ALU zero flag, same cycle.
- mem_ready  in  1  memory completes current read/write this cycle.
- pc_write, ir_write, reg_write, mem_read, mem_write  out  1 each  datapath strobes.
- iord  out  1  memory address: 0 = PC, 1 = ALUOut.
- reg_dst  out  2  00 rt, 01 rd, 10 $31.
- mem_to_reg  out  2  00 ALUOut, 01 MDR, 10 PC.
- alu_src_a  out  1  0 PC, 1 A.
- alu_src_b  out  2  00 B, 01 const 4, 10 extended imm, 11 sign-ext imm<<2.
- ext_sel  out  1  0 sign-extend, 1 zero-extend.
- alu_op  out  4  to ALU control.
- pc_source  out  2  00 ALU result, 01 ALUOut, 10 jump target, 11 A (jr).
- state  out  4  current state (debug).
- illegal  out  1  high in TRAP.
- instret  out  32  retired-instruction count.

## Operation
- alu_op encoding: 0000 add (lw/sw/addi/address/PC+4), 0001 beq, 0010 ori, 0011 slti, 0110 bne, 1011 lui, 1100 xori, 1010 andi, 1111 R-type.
- Outputs combinational from registered state plus opcode/funct/zero/mem_ready. Any output not listed in a state is 0.
- States (encoding): FETCH 0, DECODE 1, MEMADDR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXE_R 6, RWB 7, BRANCH 8, JUMP 9, EXE_I 10, IWB 11, TRAP 15.
- FETCH: mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=0000, pc_source=00. ir_write=pc_write=mem_ready. Stay until mem_ready, then DECODE.
- DECODE: alu_src_a=0, alu_src_b=11, alu_op=0000 (branch target into ALUOut). Next by opcode: 100011/101011 -> MEMADDR; 000000 -> EXE_R; 000100/000101 -> BRANCH; 000010/000011 -> JUMP; 001000/001010/001100/001101/001110/001111 -> EXE_I; any other -> TRAP.
- MEMADDR: alu_src_a=1, alu_src_b=10, ext_sel=0, alu_op=0000. lw -> MEMRD, sw -> MEMWR.
- MEMRD: mem_read=1, iord=1; wait mem_ready -> MEMWB.
- MEMWB: reg_write=1, reg_dst=00, mem_to_reg=01 -> FETCH.
- MEMWR: mem_write=1, iord=1; wait mem_ready -> FETCH.
- EXE_R: alu_src_a=1, alu_src_b=00, alu_op=1111. funct=001000 (jr): pc_write=1, pc_source=11 -> FETCH; otherwise -> RWB.
- RWB: reg_write=1, reg_dst=01, mem_to_reg=00 -> FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=0001 (beq) or 0110 (bne), pc_source=01; pc_write=zero (beq) or ~zero (bne) -> FETCH.
- JUMP: pc_write=1, pc_source=10; jal additionally reg_write=1, reg_dst=10, mem_to_reg=10 -> FETCH.
- EXE_I: alu_src_a=1, alu_src_b=10, alu_op per opcode, ext_sel=1 for andi/ori/xori, else 0 -> IWB.
- IWB: reg_write=1, reg_dst=00, mem_to_reg=00 -> FETCH.
- TRAP: illegal=1, all strobes 0; sticky until reset; instret frozen.
- instret increments by 1 on every clock edge where the FSM moves from a completing state (MEMWB, MEMWR+mem_ready, EXE_R on jr, RWB, BRANCH, JUMP, IWB) into FETCH; wraps 0xFFFFFFFF -> 0.

## Timing
- rst_n low: state=FETCH, instret=0, illegal=0 immediately (async); pc_write, ir_write, reg_write, mem_read, mem_write forced 0 while rst_n low. First fetch on the first clk edge after release.
- Reset mid-instruction aborts it; no strobe asserted after rst_n falls, count not incremented.
- Latency with mem_ready held 1: lw 5, sw 4, R-type 4, jr 3, I-type 4, beq/bne 3, j/jal 3 cycles. Each mem_ready=0 cycle in FETCH/MEMRD/MEMWR adds one cycle; outputs hold steady during the stall.
- mem_ready ignored outside FETCH, MEMRD, MEMWR.

## Test plan
- Reset then mem_ready=1, IR=lw (100011) -> states 0,1,2,3,4,0; reg_write=1, mem_to_reg=01 in state 4; instret=1.
- add (000000, funct 100000) with mem_ready low 2 cycles in FETCH -> FETCH held 3 cycles, ir_write only on 3rd; RWB reg_dst=01; total 6 cycles.
- beq with zero=1 then zero=0 -> pc_write=1 then 0 in BRANCH, alu_op=0001, pc_source=01; bne inverts.
- jal -> JUMP with reg_dst=10, mem_to_reg=10, pc_write=1; jr (funct 001000) -> pc_source=11 in EXE_R, 3 cycles, no reg_write.
- ori/lui -> alu_op 0010/1011, ext_sel 1/0; opcode 111111 -> TRAP, illegal=1 held 10 cycles, instret unchanged, cleared by rst_n.
- Preload via 2^32 retirements (or force) instret=0xFFFFFFFF, retire one -> 0; assert rst_n in MEMRD -> strobes 0 immediately, state=0.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// Purpose : main control FSM of the multi-cycle MIPS core; sequences fetch/decode/execute/mem/write-back.
// Latency : lw 5, sw 4, R-type 4, I-type 4, jr/beq/bne/j/jal 3 cycles with mem_ready held high.
// Backpr. : stalls in FETCH/MEMRD/MEMWR while mem_ready is low; outputs hold steady during the stall.
// Ports   : clk/rst_n; opcode/funct (IR fields), zero (ALU flag), mem_ready (memory handshake);
//           datapath strobes pc_write/ir_write/reg_write/mem_read/mem_write, muxes iord/reg_dst/
//           mem_to_reg/alu_src_a/alu_src_b/ext_sel/pc_source, alu_op; debug state, illegal, instret.
module multicycle_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [5:0]  opcode,
  input  logic [5:0]  funct,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        pc_write,
  output logic        ir_write,
  output logic        reg_write,
  output logic        mem_read,
  output logic        mem_write,
  output logic        iord,
  output logic [1:0]  reg_dst,
  output logic [1:0]  mem_to_reg,
  output logic        alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic        ext_sel,
  output logic [3:0]  alu_op,
  output logic [1:0]  pc_source,
  output logic [3:0]  state,
  output logic        illegal,
  output logic [31:0] instret
);

  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADDR = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    EXE_R   = 4'd6,
    RWB     = 4'd7,
    BRANCH  = 4'd8,
    JUMP    = 4'd9,
    EXE_I   = 4'd10,
    IWB     = 4'd11,
    TRAP    = 4'd15
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] FN_JR    = 6'b001000;

  state_t      state_q, state_d;
  logic [31:0] instret_q;
  logic        retire;
  logic        pc_write_c, ir_write_c, reg_write_c, mem_read_c, mem_write_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= FETCH;
      instret_q <= 32'd0;
    end else begin
      state_q <= state_d;
      if (retire)
        instret_q <= instret_q + 32'd1;
    end
  end

  always_comb begin
    state_d     = state_q;
    pc_write_c  = 1'b0;
    ir_write_c  = 1'b0;
    reg_write_c = 1'b0;
    mem_read_c  = 1'b0;
    mem_write_c = 1'b0;
    iord        = 1'b0;
    reg_dst     = 2'b00;
    mem_to_reg  = 2'b00;
    alu_src_a   = 1'b0;
    alu_src_b   = 2'b00;
    ext_sel     = 1'b0;
    alu_op      = 4'b0000;
    pc_source   = 2'b00;
    case (state_q)
      FETCH: begin
        mem_read_c = 1'b1;
        alu_src_b  = 2'b01;
        // IR and PC+4 are captured only in the cycle the read completes.
        ir_write_c = mem_ready;
        pc_write_c = mem_ready;
        if (mem_ready) state_d = DECODE;
      end
      DECODE: begin
        // Speculatively compute the branch target into ALUOut.
        alu_src_b = 2'b11;
        case (opcode)
          OP_LW, OP_SW:   state_d = MEMADDR;
          OP_RTYPE:       state_d = EXE_R;
          OP_BEQ, OP_BNE: state_d = BRANCH;
          OP_J, OP_JAL:   state_d = JUMP;
          OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI, OP_XORI, OP_LUI: state_d = EXE_I;
          default:        state_d = TRAP;
        endcase
      end
      MEMADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_d   = (opcode == OP_SW) ? MEMWR : MEMRD;
      end
      MEMRD: begin
        mem_read_c = 1'b1;
        iord       = 1'b1;
        if (mem_ready) state_d = MEMWB;
      end
      MEMWB: begin
        reg_write_c = 1'b1;
        mem_to_reg  = 2'b01;
        state_d     = FETCH;
      end
      MEMWR: begin
        mem_write_c = 1'b1;
        iord        = 1'b1;
        if (mem_ready) state_d = FETCH;
      end
      EXE_R: begin
        alu_src_a = 1'b1;
        alu_op    = 4'b1111;
        if (funct == FN_JR) begin
          pc_write_c = 1'b1;
          pc_source  = 2'b11;
          state_d    = FETCH;
        end else begin
          state_d = RWB;
        end
      end
      RWB: begin
        reg_write_c = 1'b1;
        reg_dst     = 2'b01;
        state_d     = FETCH;
      end
      BRANCH: begin
        alu_src_a  = 1'b1;
        pc_source  = 2'b01;
        alu_op     = (opcode == OP_BNE) ? 4'b0110 : 4'b0001;
        pc_write_c = (opcode == OP_BNE) ? ~zero : zero;
        state_d    = FETCH;
      end
      JUMP: begin
        pc_write_c = 1'b1;
        pc_source  = 2'b10;
        if (opcode == OP_JAL) begin
          reg_write_c = 1'b1;
          reg_dst     = 2'b10;
          mem_to_reg  = 2'b10;
        end
        state_d = FETCH;
      end
      EXE_I: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        case (opcode)
          OP_SLTI: alu_op = 4'b0011;
          OP_ANDI: alu_op = 4'b1010;
          OP_ORI:  alu_op = 4'b0010;
          OP_XORI: alu_op = 4'b1100;
          OP_LUI:  alu_op = 4'b1011;
          default: alu_op = 4'b0000;
        endcase
        // Logical immediates are zero-extended; arithmetic and lui use sign extension.
        ext_sel = (opcode == OP_ANDI) || (opcode == OP_ORI) || (opcode == OP_XORI);
        state_d = IWB;
      end
      IWB: begin
        reg_write_c = 1'b1;
        state_d     = FETCH;
      end
      TRAP:    state_d = TRAP;
      default: state_d = TRAP;
    endcase
  end

  // Every non-FETCH state that hands back to FETCH finishes an instruction;
  // FETCH->FETCH is a stall and TRAP never leaves.
  assign retire = (state_d == FETCH) && (state_q != FETCH);

  // Strobes are gated so nothing reaches the datapath while reset is held,
  // even though the async reset already parks the FSM in FETCH.
  assign pc_write  = pc_write_c  & rst_n;
  assign ir_write  = ir_write_c  & rst_n;
  assign reg_write = reg_write_c & rst_n;
  assign mem_read  = mem_read_c  & rst_n;
  assign mem_write = mem_write_c & rst_n;

  assign state   = state_q;
  assign illegal = (state_q == TRAP);
  assign instret = instret_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Purpose : directed scoreboard bench for multicycle_ctrl.
// Latency : one expectation per clock, compared on the falling edge.
// Backpr. : mem_ready stalls are driven explicitly by the stimulus vectors.
module tb_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [5:0]  opcode, funct;
  logic        zero, mem_ready;
  logic        pc_write, ir_write, reg_write, mem_read, mem_write, iord;
  logic [1:0]  reg_dst, mem_to_reg, alu_src_b, pc_source;
  logic        alu_src_a, ext_sel, illegal;
  logic [3:0]  alu_op, state;
  logic [31:0] instret;

  always #5 clk = ~clk;

  multicycle_ctrl dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .pc_write(pc_write), .ir_write(ir_write),
    .reg_write(reg_write), .mem_read(mem_read), .mem_write(mem_write),
    .iord(iord), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .ext_sel(ext_sel),
    .alu_op(alu_op), .pc_source(pc_source), .state(state),
    .illegal(illegal), .instret(instret)
  );

  typedef struct packed {
    logic [3:0]  st;
    logic [5:0]  str;  // {pc_write, ir_write, reg_write, mem_read, mem_write, iord}
    logic [9:0]  sel;  // {reg_dst, mem_to_reg, alu_src_a, alu_src_b, ext_sel, pc_source}
    logic [3:0]  aop;
    logic        ill;
    logic [31:0] ic;
  } exp_t;

  exp_t q[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  // Hand-derived mux patterns per state.
  localparam logic [9:0] SF   = 10'b00_00_0_01_0_00;
  localparam logic [9:0] SD   = 10'b00_00_0_11_0_00;
  localparam logic [9:0] SMA  = 10'b00_00_1_10_0_00;
  localparam logic [9:0] SMWB = 10'b00_01_0_00_0_00;
  localparam logic [9:0] SER  = 10'b00_00_1_00_0_00;
  localparam logic [9:0] SJR  = 10'b00_00_1_00_0_11;
  localparam logic [9:0] SRWB = 10'b01_00_0_00_0_00;
  localparam logic [9:0] SBR  = 10'b00_00_1_00_0_01;
  localparam logic [9:0] SJ   = 10'b00_00_0_00_0_10;
  localparam logic [9:0] SJAL = 10'b10_10_0_00_0_10;
  localparam logic [9:0] SEIZ = 10'b00_00_1_10_1_00;
  localparam logic [9:0] S0   = 10'b0;
  localparam logic [5:0] TF   = 6'b110100;
  localparam logic [5:0] TFS  = 6'b000100;
  localparam logic [5:0] TRD  = 6'b000101;
  localparam logic [5:0] TWB  = 6'b001000;
  localparam logic [5:0] TWR  = 6'b000011;
  localparam logic [5:0] TPC  = 6'b100000;
  localparam logic [5:0] TJAL = 6'b101000;
  localparam logic [5:0] T0   = 6'b000000;

  localparam logic [5:0] OP_R = 6'b000000, OP_J = 6'b000010, OP_JAL = 6'b000011;
  localparam logic [5:0] OP_BEQ = 6'b000100, OP_BNE = 6'b000101, OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_ORI = 6'b001101, OP_LUI = 6'b001111;
  localparam logic [5:0] OP_LW = 6'b100011, OP_SW = 6'b101011, OP_BAD = 6'b111111;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h, want %h", name, $time, got, want);
    end
  endtask

  // Monitor: one expectation per cycle, checked mid-cycle on the falling edge.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("state",   32'(state), 32'(e.st));
      chk("strobes", 32'({pc_write, ir_write, reg_write, mem_read, mem_write, iord}), 32'(e.str));
      chk("muxsel",  32'({reg_dst, mem_to_reg, alu_src_a, alu_src_b, ext_sel, pc_source}), 32'(e.sel));
      chk("alu_op",  32'(alu_op), 32'(e.aop));
      chk("illegal", 32'(illegal), 32'(e.ill));
      chk("instret", instret, e.ic);
    end
  end

  task automatic cy(input logic [5:0] op, input logic [5:0] fn, input logic z, input logic mr,
                    input logic [3:0] st, input logic [5:0] str, input logic [9:0] sel,
                    input logic [3:0] aop, input logic ill, input logic [31:0] ic);
    exp_t e;
    opcode = op; funct = fn; zero = z; mem_ready = mr;
    e.st = st; e.str = str; e.sel = sel; e.aop = aop; e.ill = ill; e.ic = ic;
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  // FETCH with mem_ready high, then DECODE.
  task automatic fd(input logic [5:0] op, input logic [5:0] fn, input logic [31:0] ic);
    cy(op, fn, 1'b0, 1'b1, 4'd0, TF, SF, 4'h0, 1'b0, ic);
    cy(op, fn, 1'b0, 1'b1, 4'd1, T0, SD, 4'h0, 1'b0, ic);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; opcode = 6'd0; funct = 6'd0; zero = 1'b0; mem_ready = 1'b1;
    @(posedge clk); #1;
    // Reset: FETCH, strobes forced low even with mem_ready high.
    cy(OP_LW, 6'd0, 1'b0, 1'b1, 4'd0, T0, SF, 4'h0, 1'b0, 32'd0);
    rst_n = 1'b1;

    // lw: 0,1,2,3,4
    fd(OP_LW, 6'd0, 32'd0);
    cy(OP_LW, 6'd0, 1'b0, 1'b1, 4'd2, T0,  SMA,  4'h0, 1'b0, 32'd0);
    cy(OP_LW, 6'd0, 1'b0, 1'b1, 4'd3, TRD, S0,   4'h0, 1'b0, 32'd0);
    cy(OP_LW, 6'd0, 1'b0, 1'b1, 4'd4, TWB, SMWB, 4'h0, 1'b0, 32'd0);

    // add with two FETCH stall cycles
    cy(OP_R, 6'h20, 1'b0, 1'b0, 4'd0, TFS, SF, 4'h0, 1'b0, 32'd1);
    cy(OP_R, 6'h20, 1'b0, 1'b0, 4'd0, TFS, SF, 4'h0, 1'b0, 32'd1);
    fd(OP_R, 6'h20, 32'd1);
    cy(OP_R, 6'h20, 1'b0, 1'b1, 4'd6, T0,  SER,  4'hF, 1'b0, 32'd1);
    cy(OP_R, 6'h20, 1'b0, 1'b1, 4'd7, TWB, SRWB, 4'h0, 1'b0, 32'd1);

    // beq / bne, both zero polarities
    fd(OP_BEQ, 6'd0, 32'd2);
    cy(OP_BEQ, 6'd0, 1'b1, 1'b1, 4'd8, TPC, SBR, 4'h1, 1'b0, 32'd2);
    fd(OP_BEQ, 6'd0, 32'd3);
    cy(OP_BEQ, 6'd0, 1'b0, 1'b1, 4'd8, T0,  SBR, 4'h1, 1'b0, 32'd3);
    fd(OP_BNE, 6'd0, 32'd4);
    cy(OP_BNE, 6'd0, 1'b1, 1'b1, 4'd8, T0,  SBR, 4'h6, 1'b0, 32'd4);
    fd(OP_BNE, 6'd0, 32'd5);
    cy(OP_BNE, 6'd0, 1'b0, 1'b1, 4'd8, TPC, SBR, 4'h6, 1'b0, 32'd5);

    // jal, j, jr
    fd(OP_JAL, 6'd0, 32'd6);
    cy(OP_JAL, 6'd0, 1'b0, 1'b1, 4'd9, TJAL, SJAL, 4'h0, 1'b0, 32'd6);
    fd(OP_J, 6'd0, 32'd7);
    cy(OP_J, 6'd0, 1'b0, 1'b1, 4'd9, TPC, SJ, 4'h0, 1'b0, 32'd7);
    fd(OP_R, 6'h08, 32'd8);
    cy(OP_R, 6'h08, 1'b0, 1'b1, 4'd6, TPC, SJR, 4'hF, 1'b0, 32'd8);

    // sw with one MEMWR stall
    fd(OP_SW, 6'd0, 32'd9);
    cy(OP_SW, 6'd0, 1'b0, 1'b1, 4'd2, T0,  SMA, 4'h0, 1'b0, 32'd9);
    cy(OP_SW, 6'd0, 1'b0, 1'b0, 4'd5, TWR, S0,  4'h0, 1'b0, 32'd9);
    cy(OP_SW, 6'd0, 1'b0, 1'b1, 4'd5, TWR, S0,  4'h0, 1'b0, 32'd9);

    // ori (zero-extend), lui (sign-extend) with mem_ready low in DECODE
    fd(OP_ORI, 6'd0, 32'd10);
    cy(OP_ORI, 6'd0, 1'b0, 1'b1, 4'd10, T0,  SEIZ, 4'h2, 1'b0, 32'd10);
    cy(OP_ORI, 6'd0, 1'b0, 1'b1, 4'd11, TWB, S0,   4'h0, 1'b0, 32'd10);
    cy(OP_LUI, 6'd0, 1'b0, 1'b1, 4'd0,  TF,  SF,   4'h0, 1'b0, 32'd11);
    cy(OP_LUI, 6'd0, 1'b0, 1'b0, 4'd1,  T0,  SD,   4'h0, 1'b0, 32'd11);
    cy(OP_LUI, 6'd0, 1'b0, 1'b1, 4'd10, T0,  SMA,  4'hB, 1'b0, 32'd11);
    cy(OP_LUI, 6'd0, 1'b0, 1'b1, 4'd11, TWB, S0,   4'h0, 1'b0, 32'd11);

    // instret wrap: preload all-ones, retire addi
    force dut.instret_q = 32'hFFFF_FFFF;
    #1;
    release dut.instret_q;
    fd(OP_ADDI, 6'd0, 32'hFFFF_FFFF);
    cy(OP_ADDI, 6'd0, 1'b0, 1'b1, 4'd10, T0,  SMA, 4'h0, 1'b0, 32'hFFFF_FFFF);
    cy(OP_ADDI, 6'd0, 1'b0, 1'b1, 4'd11, TWB, S0,  4'h0, 1'b0, 32'hFFFF_FFFF);

    // illegal opcode -> TRAP, sticky for 10 cycles regardless of inputs
    fd(OP_BAD, 6'd0, 32'd0);
    for (int i = 0; i < 10; i++)
      cy((i % 2 == 0) ? OP_BAD : OP_R, 6'd0, i[0], i[1], 4'd15, T0, S0, 4'h0, 1'b1, 32'd0);

    // reset clears TRAP
    rst_n = 1'b0;
    cy(OP_BAD, 6'd0, 1'b0, 1'b1, 4'd0, T0, SF, 4'h0, 1'b0, 32'd0);
    rst_n = 1'b1;

    // reset asserted while in MEMRD: abort, strobes low, no count
    fd(OP_LW, 6'd0, 32'd0);
    cy(OP_LW, 6'd0, 1'b0, 1'b1, 4'd2, T0, SMA, 4'h0, 1'b0, 32'd0);
    rst_n = 1'b0;
    cy(OP_LW, 6'd0, 1'b0, 1'b1, 4'd0, T0, SF, 4'h0, 1'b0, 32'd0);
    rst_n = 1'b1;

    // normal operation resumes
    fd(OP_J, 6'd0, 32'd0);
    cy(OP_J, 6'd0, 1'b0, 1'b1, 4'd9, TPC, SJ, 4'h0, 1'b0, 32'd0);
    cy(OP_J, 6'd0, 1'b0, 1'b1, 4'd0, TF,  SF, 4'h0, 1'b0, 32'd1);

    for (int i = 0; i < 5 && q.size() > 0; i++) @(negedge clk);
    #1;
    if (q.size() != 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL drain: %0d expectations left, want 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
